// File: rtl/uart_bus_master_pkg.sv
// Shared byte constants and main FSM encoding for uart_bus_master.
// Command, reply and checksum-error bytes travel on the UART link.
package uart_bus_master_pkg;

    localparam logic [7:0] CmdWrite   = 8'h57;
    localparam logic [7:0] CmdRead    = 8'h52;
    localparam logic [7:0] RspOk      = 8'h4B;
    localparam logic [7:0] RspUnknown = 8'h3F;
    localparam logic [7:0] RspChkErr  = 8'h21;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StChk,
        StBus,
        StReply
    } main_state_e;

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte PHY: rx synchronizer and deserializer (byte_valid / frame_err pulses)
// plus a tx serializer with a start/ready handshake and a done pulse.
module uart_byte_phy #(
    parameter int unsigned BIT_CYC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);

    localparam int unsigned CntW = $clog2(BIT_CYC);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYC - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(BIT_CYC / 2 - 1);

    typedef enum logic [1:0] {RxHunt, RxStart, RxData, RxStop} rx_state_e;

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;

    logic            tx_active_q, tx_active_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_sh_q, tx_sh_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state_q  <= RxHunt;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            tx_active_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '1;
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            tx_active_q <= tx_active_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state_q)
            RxHunt: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_sync) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HalfCnt) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? RxHunt : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == LastCnt) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_sync, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == LastCnt) begin
                    rx_state_d = RxHunt;
                    byte_valid = rx_sync;
                    frame_err  = !rx_sync;
                end
            end
            default: rx_state_d = RxHunt;
        endcase
    end

    assign rx_data  = rx_sh_q;
    assign tx_done  = tx_active_q && (tx_cnt_q == LastCnt) && (tx_bit_q == 4'd9);
    // A new byte may be loaded in the last stop-bit cycle so frames run back to back.
    assign tx_ready = !tx_active_q || tx_done;
    assign tx       = tx_sh_q[0];

    always_comb begin
        tx_active_d = tx_active_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_sh_d     = tx_sh_q;
        if (tx_active_q) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            if (tx_cnt_q == LastCnt) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 4'd1;
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                if (tx_bit_q == 4'd9) tx_active_d = 1'b0;
            end
        end
        if (tx_start && tx_ready) begin
            tx_active_d = 1'b1;
            tx_cnt_d    = '0;
            tx_bit_d    = '0;
            tx_sh_d     = {1'b1, tx_data, 1'b0};
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven single-beat bus initiator: 'W' A3..A0 D3..D0 writes, 'R' A3..A0 reads.
// Optional trailing XOR checksum byte when UART_BUS_MASTER_CHECKSUM_EN is defined.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = 62500000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned GAP_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] a,
    output logic [31:0] d,
    output logic        we,
    output logic        rd,
    input  logic [31:0] spo,
    input  logic        ready,
    output logic        busy
);

    localparam int unsigned BIT_CYC = CLOCK_FREQ / BAUD_RATE;
    localparam logic [31:0] GapLast = 32'(GAP_TIMEOUT - 1);

    logic [7:0]  rx_data, tx_byte;
    logic        byte_valid, frame_err, tx_start, tx_ready, tx_done, abort;

    main_state_e state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [31:0] a_q, a_d, d_q, d_d;
    logic        we_q, we_d, rd_q, rd_d, busy_q, busy_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  rsp_cnt_q, rsp_cnt_d;
    logic [31:0] gap_q, gap_d;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    uart_byte_phy #(
        .BIT_CYC (BIT_CYC)
    ) u_phy (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .tx_start   (tx_start),
        .tx_data    (tx_byte),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx         (tx)
    );

    assign abort = !byte_valid && (frame_err || gap_q == GapLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            a_q        <= '0;
            d_q        <= '0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            rsp_q      <= '0;
            rsp_cnt_q  <= '0;
            gap_q      <= '0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            a_q        <= a_d;
            d_q        <= d_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            rsp_q      <= rsp_d;
            rsp_cnt_q  <= rsp_cnt_d;
            gap_q      <= gap_d;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        a_d        = a_q;
        d_d        = d_q;
        we_d       = we_q;
        rd_d       = rd_q;
        busy_d     = busy_q;
        rsp_d      = rsp_q;
        rsp_cnt_d  = rsp_cnt_q;
        gap_d      = '0;
        tx_start   = 1'b0;
        tx_byte    = rsp_q[31:24];
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        chk_d      = chk_q;
        if (byte_valid) chk_d = chk_q ^ rx_data;
`endif
        unique case (state_q)
            // The command byte is decoded on arrival; '?' starts transmitting at once.
            StIdle: begin
                if (byte_valid) begin
                    busy_d     = 1'b1;
                    byte_cnt_d = '0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                    chk_d      = rx_data;
`endif
                    if (rx_data == CmdWrite || rx_data == CmdRead) begin
                        is_write_d = (rx_data == CmdWrite);
                        state_d    = StAddr;
                    end else begin
                        tx_start  = 1'b1;
                        tx_byte   = RspUnknown;
                        rsp_cnt_d = '0;
                        state_d   = StReply;
                    end
                end
            end
            StAddr: begin
                gap_d = gap_q + 32'd1;
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (byte_valid) begin
                    gap_d      = '0;
                    addr_d     = {addr_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = StData;
                        end else begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                            state_d = StChk;
`else
                            a_d     = {addr_q[23:0], rx_data};
                            rd_d    = 1'b1;
                            state_d = StBus;
`endif
                        end
                    end
                end
            end
            StData: begin
                gap_d = gap_q + 32'd1;
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (byte_valid) begin
                    gap_d      = '0;
                    data_d     = {data_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                        state_d = StChk;
`else
                        a_d     = addr_q;
                        d_d     = {data_q[23:0], rx_data};
                        we_d    = 1'b1;
                        state_d = StBus;
`endif
                    end
                end
            end
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            StChk: begin
                gap_d = gap_q + 32'd1;
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (byte_valid) begin
                    gap_d = '0;
                    if (rx_data == chk_q) begin
                        a_d     = addr_q;
                        state_d = StBus;
                        if (is_write_q) begin
                            d_d  = data_q;
                            we_d = 1'b1;
                        end else begin
                            rd_d = 1'b1;
                        end
                    end else begin
                        tx_start  = 1'b1;
                        tx_byte   = RspChkErr;
                        rsp_cnt_d = '0;
                        state_d   = StReply;
                    end
                end
            end
`endif
            StBus: begin
                if (ready) begin
                    we_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = StReply;
                    if (rd_q) begin
                        rsp_d     = spo;
                        rsp_cnt_d = 3'd4;
                    end else begin
                        rsp_d     = {RspOk, 24'h0};
                        rsp_cnt_d = 3'd1;
                    end
                end
            end
            StReply: begin
                if (tx_ready && rsp_cnt_q != 3'd0) begin
                    tx_start  = 1'b1;
                    rsp_d     = {rsp_q[23:0], 8'h00};
                    rsp_cnt_d = rsp_cnt_q - 3'd1;
                end else if (tx_done) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign a    = a_q;
    assign d    = d_q;
    assign we   = we_q;
    assign rd   = rd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master at BIT_CYC=10; define
// UART_BUS_MASTER_CHECKSUM_EN to exercise the checksum build.
module tb_uart_bus_master;

    localparam int unsigned BIT_CYC = 10;
    localparam int unsigned GAP     = 300;
    localparam logic [31:0] RD_DATA = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        tx, we, rd, ready, busy;
    logic [31:0] a, d, spo;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int rd_age = 0;
    int cyc = 0;
    int we_cnt = 0;
    int rd_cnt = 0;
    int last_strobe = 0;
    int stop_err = 0;
    logic [31:0] we_a = '0, we_d = '0, rd_a = '0;
    logic [7:0]  rx_q[$];
    int          start_cyc[$];
    logic [7:0]  frame[$];

    uart_bus_master #(
        .CLOCK_FREQ  (1000000),
        .BAUD_RATE   (100000),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .tx    (tx),
        .a     (a),
        .d     (d),
        .we    (we),
        .rd    (rd),
        .spo   (spo),
        .ready (ready),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    assign spo = RD_DATA;
    // mode 0: ready tied high; mode 1: ready in the 4th strobe cycle; mode 2: never
    assign ready = (ready_mode == 0) || (ready_mode == 1 && rd && rd_age == 4);

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        rd_age <= rd ? rd_age + 1 : 0;
        if (we) begin
            we_cnt      <= we_cnt + 1;
            we_a        <= a;
            we_d        <= d;
            last_strobe <= cyc;
        end
        if (rd) begin
            rd_cnt      <= rd_cnt + 1;
            rd_a        <= a;
            last_strobe <= cyc;
        end
    end

    // Reply receiver: samples tx mid-bit, records start-bit cycle of each byte.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                start_cyc.push_back(cyc);
                repeat (BIT_CYC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT_CYC) @(negedge clk);
                if (tx !== 1'b1) stop_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input bit add_chk);
        logic [7:0] x;
        x = 8'h00;
        foreach (frame[i]) begin
            send_byte(frame[i], 1'b1);
            x = x ^ frame[i];
        end
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        if (add_chk) send_byte(x, 1'b1);
`else
        if (add_chk && x === 8'hxx) $display("note: unexpected unknown frame byte");
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL reset_a got %h want 0", a); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_d got %h want 0", d); end
        checks++;
        if ({we, rd, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes got we/rd/busy=%b want 000", {we, rd, busy});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write;
        int rb, wb;
        ready_mode = 0;
        rb = rx_q.size();
        wb = we_cnt;
        frame = {8'h57, 8'h10, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(1'b1);
        for (int i = 0; i < 400 && rx_q.size() < rb + 1; i++) @(negedge clk);
        checks++;
        if (rx_q.size() != rb + 1) begin
            errors++; $display("FAIL write_reply_count got %0d want 1", rx_q.size() - rb);
        end
        checks++; if (we_cnt - wb != 1) begin errors++; $display("FAIL write_we_cycles got %0d want 1", we_cnt - wb); end
        checks++; if (we_a !== 32'h10000004) begin errors++; $display("FAIL write_addr got %h want 10000004", we_a); end
        checks++; if (we_d !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data got %h want deadbeef", we_d); end
        checks++; if (rx_q[rb] !== 8'h4B) begin errors++; $display("FAIL write_reply got %h want 4b", rx_q[rb]); end
        checks++;
        if (start_cyc[rb] - last_strobe != 2) begin
            errors++; $display("FAIL write_latency got %0d want 2", start_cyc[rb] - last_strobe);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_in_stop got %b want 1", busy); end
        repeat (BIT_CYC) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b want 0", busy); end
    endtask

    task automatic do_read(input string name, input logic [31:0] addr);
        int rb, rdb;
        ready_mode = 1;
        rb  = rx_q.size();
        rdb = rd_cnt;
        frame = {8'h52, addr[31:24], addr[23:16], addr[15:8], addr[7:0]};
        send_frame(1'b1);
        for (int i = 0; i < 800 && rx_q.size() < rb + 4; i++) @(negedge clk);
        checks++;
        if (rx_q.size() != rb + 4) begin
            errors++; $display("FAIL %s_reply_count got %0d want 4", name, rx_q.size() - rb);
        end
        checks++; if (rd_cnt - rdb != 4) begin errors++; $display("FAIL %s_rd_cycles got %0d want 4", name, rd_cnt - rdb); end
        checks++; if (rd_a !== addr) begin errors++; $display("FAIL %s_addr got %h want %h", name, rd_a, addr); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_q[rb + k] !== 8'(RD_DATA >> (24 - 8 * k))) begin
                errors++;
                $display("FAIL %s_byte%0d got %h want %h", name, k, rx_q[rb + k], 8'(RD_DATA >> (24 - 8 * k)));
            end
        end
        checks++;
        if (start_cyc[rb] - last_strobe != 2) begin
            errors++; $display("FAIL %s_latency got %0d want 2", name, start_cyc[rb] - last_strobe);
        end
        repeat (BIT_CYC) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b want 0", name, busy); end
    endtask

    task automatic test_read;
        do_read("read", 32'h00000100);
    endtask

    task automatic test_unknown;
        int rb, sb;
        rb = rx_q.size();
        sb = we_cnt + rd_cnt;
        frame = {8'h41};
        send_frame(1'b0);
        for (int i = 0; i < 300 && rx_q.size() < rb + 1; i++) @(negedge clk);
        checks++; if (rx_q[rb] !== 8'h3F) begin errors++; $display("FAIL unknown_reply got %h want 3f", rx_q[rb]); end
        checks++; if (we_cnt + rd_cnt != sb) begin errors++; $display("FAIL unknown_strobe got %0d want 0", we_cnt + rd_cnt - sb); end
        repeat (BIT_CYC) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unknown_busy got %b want 0", busy); end
    endtask

    task automatic test_gap_framing;
        int rb, sb;
        rb = rx_q.size();
        sb = we_cnt + rd_cnt;
        frame = {8'h57, 8'h10};
        send_frame(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy_mid got %b want 1", busy); end
        repeat (GAP + 1) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_abort_busy got %b want 0", busy); end
        send_byte(8'hA5, 1'b0);
        repeat (3 * BIT_CYC) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_busy got %b want 0", busy); end
        checks++; if (we_cnt + rd_cnt != sb) begin errors++; $display("FAIL gap_strobe got %0d want 0", we_cnt + rd_cnt - sb); end
        checks++; if (rx_q.size() != rb) begin errors++; $display("FAIL gap_reply got %0d want 0", rx_q.size() - rb); end
        do_read("gap_read", 32'h00000008);
    endtask

    task automatic test_reset_mid_read;
        int n;
        ready_mode = 2;
        frame = {8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
        send_frame(1'b1);
        n = 0;
        while (rd !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rd !== 1'b1) begin errors++; $display("FAIL rstmid_rd_seen got %b want 1", rd); end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (rd !== 1'b0) begin errors++; $display("FAIL rstmid_rd got %b want 0", rd); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_read("post_rst_read", 32'h0000000C);
    endtask

`ifdef UART_BUS_MASTER_CHECKSUM_EN
    task automatic test_checksum;
        int rb, rdb;
        ready_mode = 1;
        rb  = rx_q.size();
        rdb = rd_cnt;
        frame = {8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        for (int i = 0; i < 300 && rx_q.size() < rb + 1; i++) @(negedge clk);
        checks++; if (rx_q[rb] !== 8'h21) begin errors++; $display("FAIL chk_bad_reply got %h want 21", rx_q[rb]); end
        checks++; if (rd_cnt != rdb) begin errors++; $display("FAIL chk_bad_rd got %0d want 0", rd_cnt - rdb); end
        repeat (BIT_CYC) @(negedge clk);
        do_read("chk_good_read", 32'h00000000);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unknown();
        test_gap_framing();
        test_reset_mid_read();
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        test_checksum();
`endif
        checks++; if (stop_err != 0) begin errors++; $display("FAIL reply_stop_bits got %0d bad want 0", stop_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
